fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter PC_BASE, default 32'h0000_3000, meaning byte address of instruction ROM word 0.
REQ-002 SHALL have parameter ROM_BYTES, default 32'h0000_8000, meaning instruction ROM size in bytes (8192 words).
REQ-003 SHALL have parameters MULT_CYC, default 5, and DIV_CYC, default 10, meaning multiply and divide busy lengths in cycles.
REQ-004 SHALL have ports: clk  input  1  clock; reset  input  1  synchronous, active-high.
REQ-005 SHALL have ports: pc_f  input  32  current fetch PC (PC_BASE-based byte address); npc  output  32  next PC to fetch unit; freeze  output  1  hold fetch PC.
REQ-006 SHALL have ports: redirect_valid  input  1  branch/jump taken; redirect_target  input  32  jump/branch target.
REQ-007 SHALL have ports: load_use_stall  input  1  data hazard from decode; md_start  input  1  multiply/divide issued; md_is_div  input  1  issued op is divide; md_use  input  1  decode instruction reads HI/LO or issues MD.
REQ-008 SHALL have ports: md_busy  output  1  MD unit busy; addr_err  output  1  one-cycle pulse, rejected redirect.

Function
REQ-009 SHALL keep a 4-bit md_cnt: md_start with md_cnt==0 loads DIV_CYC if md_is_div, else MULT_CYC; md_cnt!=0 decrements by 1 each cycle; md_start while md_cnt!=0 is ignored.
REQ-010 SHALL drive md_busy = (md_cnt != 0), registered-count based (first busy cycle is the cycle after md_start).
REQ-011 SHALL drive freeze = load_use_stall | (md_use & (md_busy | md_start)), combinationally.
REQ-012 SHALL treat a redirect as bad when redirect_target[1:0]!=0, or target < PC_BASE, or target >= PC_BASE+ROM_BYTES; bad redirect: addr_err=1 that cycle, redirect discarded, not captured.
REQ-013 SHALL implement state machine RUN, HOLD, HOLD_PEND with registered pend_target[31:0].
REQ-014 RUN: freeze=0 -> stay; freeze=1 with good redirect -> HOLD_PEND (capture target); freeze=1 otherwise -> HOLD.
REQ-015 HOLD: freeze=1 with good redirect -> HOLD_PEND (capture); freeze=0 -> RUN.
REQ-016 HOLD_PEND: freeze=1 with good redirect -> overwrite pend_target, stay; freeze=0 -> RUN, pending consumed.
REQ-017 SHALL compute npc with priority: freeze=1 -> pc_f; good redirect_valid -> redirect_target; state HOLD_PEND -> pend_target; else sequential.
REQ-018 Sequential npc SHALL be pc_f+4, wrapping to PC_BASE when pc_f+4 == PC_BASE+ROM_BYTES.
REQ-019 A good redirect arriving in the release cycle of HOLD_PEND SHALL win over pend_target; pending is discarded.
REQ-020 npc and freeze SHALL have zero-cycle latency from inputs; only md_cnt, state, pend_target are registered.

Reset
REQ-021 While reset=1: npc=PC_BASE, freeze=0, addr_err=0, md_busy=0 (forced, combinational override).
REQ-022 On clock edge with reset=1: md_cnt=0, state=RUN, pend_target=PC_BASE; reset mid-MD-operation or mid-HOLD_PEND drops the operation and pending redirect.

Structure
REQ-023 PC_BASE, ROM_BYTES, MULT_CYC, DIV_CYC defaults and state encoding (RUN=2'd0, HOLD=2'd1, HOLD_PEND=2'd2) SHALL live in the shared CPU constants package.
REQ-024 The MD busy counter SHALL be sub-module md_busy_cnt; everything else stays in fetch_ctrl.

Verification
REQ-025 Reset, then pc_f=0x3000, no stalls -> npc=0x3004, freeze=0, md_busy=0.
REQ-026 pc_f=0x3100, redirect_valid=1, target=0x3200 -> npc=0x3200; target=0x3202 -> npc=0x3104, addr_err=1 one cycle.
REQ-027 md_start=1, md_is_div=1, md_use=1 held -> freeze=1 same cycle, md_busy high for exactly 10 cycles, freeze drops with md_busy.
REQ-028 load_use_stall=1 two cycles, good redirect 0x3400 in first stall cycle -> state HOLD_PEND, npc=pc_f while frozen, npc=0x3400 in release cycle.
REQ-029 pc_f=0x AFFC (PC_BASE+ROM_BYTES-4), no redirect -> npc=0x3000; reset asserted during HOLD_PEND -> npc=0x3000, pending lost after release.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared CPU fetch constants, FSM encoding and PC helper.
package fetch_ctrl_pkg;
  localparam logic [31:0] PC_BASE_DEF = 32'h0000_3000;
  localparam logic [31:0] ROM_BYTES_DEF = 32'h0000_8000;
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF = 10;
  typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, HOLD_PEND = 2'd2} fetch_state_e;
  function automatic logic [31:0] seq_pc(input logic [31:0] pc, input logic [31:0] base, input logic [31:0] size);
    return (pc + 32'd4 == base + size) ? base : pc + 32'd4;
  endfunction
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: fetch/decode/MD signals between the pipeline and fetch_ctrl.
interface fetch_ctrl_if;
  logic [31:0] pc_f;
  logic [31:0] npc;
  logic [31:0] redirect_target;
  logic redirect_valid;
  logic load_use_stall;
  logic md_start;
  logic md_is_div;
  logic md_use;
  logic freeze;
  logic md_busy;
  logic addr_err;
  modport master(
    output pc_f, redirect_valid, redirect_target, load_use_stall, md_start, md_is_div, md_use,
    input npc, freeze, md_busy, addr_err
  );
  modport slave(
    input pc_f, redirect_valid, redirect_target, load_use_stall, md_start, md_is_div, md_use,
    output npc, freeze, md_busy, addr_err
  );
endinterface

// File: rtl/fetch_ctrl_md_busy_cnt.sv
// md_busy_cnt: multiply/divide busy down-counter; starts while busy are ignored.
module md_busy_cnt import fetch_ctrl_pkg::*; #(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_is_div,
  output logic o_busy
);
  logic [3:0] r_cnt;
  always_ff @(posedge clk)
    if (reset) r_cnt <= '0;
    else if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    else if (i_start) r_cnt <= i_is_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
  assign o_busy = r_cnt != 4'd0;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: next-PC selection, fetch freeze and pending-redirect capture.
module fetch_ctrl import fetch_ctrl_pkg::*; #(
  parameter logic [31:0] PC_BASE = PC_BASE_DEF,
  parameter logic [31:0] ROM_BYTES = ROM_BYTES_DEF,
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC = DIV_CYC_DEF
) (
  input logic clk,
  input logic reset,
  fetch_ctrl_if.slave bus
);
  localparam logic [31:0] PC_END = PC_BASE + ROM_BYTES;
  fetch_state_e r_state;
  logic [31:0] r_pend_target;
  logic w_md_busy, w_freeze, w_bad, w_good;
  md_busy_cnt #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) u_md (
    .clk(clk),
    .reset(reset),
    .i_start(bus.md_start),
    .i_is_div(bus.md_is_div),
    .o_busy(w_md_busy)
  );
  always_comb begin
    w_bad = bus.redirect_target[1:0] != 2'd0 || bus.redirect_target < PC_BASE || bus.redirect_target >= PC_END;
    w_good = bus.redirect_valid & ~w_bad;
    w_freeze = bus.load_use_stall | (bus.md_use & (w_md_busy | bus.md_start));
  end
  // reset overrides every output combinationally, not just the registers
  assign bus.freeze = ~reset & w_freeze;
  assign bus.md_busy = ~reset & w_md_busy;
  assign bus.addr_err = ~reset & bus.redirect_valid & w_bad;
  assign bus.npc = reset ? PC_BASE :
                   w_freeze ? bus.pc_f :
                   w_good ? bus.redirect_target :
                   r_state == HOLD_PEND ? r_pend_target :
                   seq_pc(bus.pc_f, PC_BASE, ROM_BYTES);
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= RUN;
      r_pend_target <= PC_BASE;
    end else if (w_freeze && w_good) begin
      r_state <= HOLD_PEND;
      r_pend_target <= bus.redirect_target;
    end else if (w_freeze) r_state <= r_state == RUN ? HOLD : r_state;
    else r_state <= RUN;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed literal checks plus random stimulus against an interval/pending model.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;
  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam logic [31:0] ENDA = 32'h0000_B000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  fetch_ctrl_if bus();
  fetch_ctrl dut(.clk(clk), .reset(reset), .bus(bus.slave));
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // model: MD busy as a cycle interval, redirect as an optional pending target
  int cyc = 0;
  int busy_from = 0;
  int busy_to = -1;
  bit pend_v = 0;
  logic [31:0] pend_t = '0;
  function automatic bit m_busy();
    return !reset && cyc >= busy_from && cyc <= busy_to;
  endfunction
  function automatic bit m_ok(input logic [31:0] t);
    return t[1:0] == 2'd0 && t >= BASE && t < ENDA;
  endfunction
  function automatic bit m_good();
    return bus.redirect_valid && m_ok(bus.redirect_target);
  endfunction
  function automatic bit m_freeze();
    return !reset && (bus.load_use_stall || (bus.md_use && (m_busy() || bus.md_start)));
  endfunction
  function automatic logic [31:0] m_npc();
    if (reset) return BASE;
    if (m_freeze()) return bus.pc_f;
    if (m_good()) return bus.redirect_target;
    if (pend_v) return pend_t;
    return (bus.pc_f + 4 == ENDA) ? BASE : bus.pc_f + 4;
  endfunction
  always @(negedge clk) begin
    chk("npc", bus.npc, m_npc());
    chk("freeze", 32'(bus.freeze), 32'(m_freeze()));
    chk("md_busy", 32'(bus.md_busy), 32'(m_busy()));
    chk("addr_err", 32'(bus.addr_err), 32'(!reset && bus.redirect_valid && !m_ok(bus.redirect_target)));
  end
  always @(posedge clk) begin
    bit fz, gd, bz;
    fz = m_freeze();
    gd = m_good();
    bz = m_busy();
    if (reset) begin
      busy_from = 0;
      busy_to = -1;
      pend_v = 0;
    end else begin
      if (bus.md_start && !bz) begin
        busy_from = cyc + 1;
        busy_to = cyc + (bus.md_is_div ? 10 : 5);
      end
      if (fz && gd) begin
        pend_v = 1;
        pend_t = bus.redirect_target;
      end else if (!fz) pend_v = 0;
    end
    cyc++;
  end
  task automatic drive(input logic [31:0] pc, input bit rv, input logic [31:0] tgt,
                       input bit lus, input bit st, input bit dv, input bit use_md);
    @(posedge clk);
    #1;
    bus.pc_f = pc;
    bus.redirect_valid = rv;
    bus.redirect_target = tgt;
    bus.load_use_stall = lus;
    bus.md_start = st;
    bus.md_is_div = dv;
    bus.md_use = use_md;
  endtask
  function automatic logic [31:0] rand_tgt();
    case ($urandom_range(0, 7))
      0: return BASE + 32'($urandom_range(0, 8191)) * 4 + 32'($urandom_range(1, 3));
      1: return BASE - 32'($urandom_range(1, 64)) * 4;
      2: return ENDA + 32'($urandom_range(0, 64)) * 4;
      3: return ($urandom_range(0, 1) != 0) ? BASE : ENDA - 4;
      default: return BASE + 32'($urandom_range(0, 8191)) * 4;
    endcase
  endfunction
  initial begin
    bus.pc_f = BASE;
    bus.redirect_valid = 0;
    bus.redirect_target = '0;
    bus.load_use_stall = 0;
    bus.md_start = 0;
    bus.md_is_div = 0;
    bus.md_use = 0;
    drive(32'h3100, 1, 32'h3203, 1, 0, 0, 0);
    #1 chk("rst_npc", bus.npc, 32'h3000);
    chk("rst_freeze", 32'(bus.freeze), 0);
    chk("rst_addr_err", 32'(bus.addr_err), 0);
    chk("rst_md_busy", 32'(bus.md_busy), 0);
    drive(32'h3000, 0, 0, 0, 0, 0, 0);
    reset = 0;
    #1 chk("seq_npc", bus.npc, 32'h3004);
    chk("seq_freeze", 32'(bus.freeze), 0);
    chk("seq_md_busy", 32'(bus.md_busy), 0);
    drive(32'h3100, 1, 32'h3200, 0, 0, 0, 0);
    #1 chk("redir_npc", bus.npc, 32'h3200);
    chk("redir_addr_err", 32'(bus.addr_err), 0);
    drive(32'h3100, 1, 32'h3202, 0, 0, 0, 0);
    #1 chk("bad_redir_npc", bus.npc, 32'h3104);
    chk("bad_redir_addr_err", 32'(bus.addr_err), 1);
    drive(32'h3104, 0, 0, 0, 0, 0, 0);
    #1 chk("addr_err_pulse_end", 32'(bus.addr_err), 0);
    drive(32'h3100, 1, 32'hB000, 0, 0, 0, 0);
    #1 chk("redir_end_npc", bus.npc, 32'h3104);
    chk("redir_end_err", 32'(bus.addr_err), 1);
    drive(32'h3100, 1, 32'h2FFC, 0, 0, 0, 0);
    #1 chk("redir_low_err", 32'(bus.addr_err), 1);
    drive(32'h3100, 1, 32'hAFFC, 0, 0, 0, 0);
    #1 chk("redir_last_npc", bus.npc, 32'hAFFC);
    drive(32'h3108, 0, 0, 0, 1, 1, 1);
    #1 chk("div_freeze_now", 32'(bus.freeze), 1);
    chk("div_busy_now", 32'(bus.md_busy), 0);
    for (int i = 0; i < 14; i++) begin
      drive(32'h3108, 0, 0, 0, 0, 0, 1);
      #1 chk("div_busy", 32'(bus.md_busy), 32'(i < 10));
      chk("div_freeze", 32'(bus.freeze), 32'(i < 10));
    end
    drive(32'h3108, 0, 0, 0, 1, 0, 0);
    #1 chk("mul_no_use_freeze", 32'(bus.freeze), 0);
    for (int i = 0; i < 7; i++) begin
      drive(32'h3108, 0, 0, 0, 0, 0, 0);
      #1 chk("mul_busy", 32'(bus.md_busy), 32'(i < 5));
    end
    drive(32'h3500, 1, 32'h3400, 1, 0, 0, 0);
    #1 chk("lu_npc0", bus.npc, 32'h3500);
    chk("lu_freeze0", 32'(bus.freeze), 1);
    drive(32'h3500, 0, 0, 1, 0, 0, 0);
    #1 chk("lu_npc1", bus.npc, 32'h3500);
    chk("lu_state", 32'(dut.r_state), 32'(HOLD_PEND));
    drive(32'h3500, 0, 0, 0, 0, 0, 0);
    #1 chk("lu_release_npc", bus.npc, 32'h3400);
    drive(32'h3400, 0, 0, 0, 0, 0, 0);
    #1 chk("pend_consumed", bus.npc, 32'h3404);
    drive(32'hAFFC, 0, 0, 0, 0, 0, 0);
    #1 chk("wrap_npc", bus.npc, 32'h3000);
    drive(32'h3500, 1, 32'h3600, 1, 0, 0, 0);
    drive(32'h3500, 1, 32'h3700, 0, 0, 0, 0);
    #1 chk("release_redir_wins", bus.npc, 32'h3700);
    drive(32'h3010, 0, 0, 0, 0, 0, 0);
    #1 chk("release_pend_dropped", bus.npc, 32'h3014);
    drive(32'h3500, 1, 32'h3800, 1, 0, 0, 0);
    drive(32'h3500, 0, 0, 1, 0, 0, 0);
    reset = 1;
    #1 chk("rst_pend_npc", bus.npc, 32'h3000);
    drive(32'h3500, 0, 0, 0, 0, 0, 0);
    reset = 0;
    #1 chk("rst_pend_lost", bus.npc, 32'h3504);
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 7) == 0) ? ENDA - 4 : BASE + 32'($urandom_range(0, 8191)) * 4,
            $urandom_range(0, 2) == 0, rand_tgt(), $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0);
      reset = $urandom_range(0, 99) == 0;
    end
    drive(BASE, 0, 0, 0, 0, 0, 0);
    reset = 0;
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
